uart_tx: RTL and testbench

UART transmitter for the serial link: accepts one byte per valid/ready handshake and serialises it on `tx` as an 8N1 frame (start, 8 data bits LSB first, stop bits). It sits directly upstream of `UART_Rec`, and its `tx` drives that receiver's `rx` line. It also serves as the synthesizable stimulus source for receiver loopback benches.

---
 rtl/uart_tx.sv | 159 +++++++++++++++
 tb/tb_uart_tx.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - 8N1/8N2 UART transmitter with valid/ready byte input
//
// Purpose: accepts one byte per data_valid/ready handshake and serialises it
// on tx as start bit, 8 data bits LSB first, optional even parity bit, and
// STOP_BITS stop bits. Each bit lasts BIT_CLK clock cycles.
//
// Optional feature macro: UART_TX_PARITY_EN (inserts an even-parity bit
// between the data bits and the stop bits).
//
// Ports:
//   clk        in   1  system clock, rising edge
//   rst_n      in   1  asynchronous active-low reset
//   data       in   8  byte to send, sampled on handshake only
//   data_valid in   1  upstream has a byte
//   ready      out  1  transmitter can accept a byte (IDLE only)
//   tx         out  1  serial line, idle high, registered
//   busy       out  1  frame in progress
module uart_tx #(
  parameter int CLK_HZ      = 66_000_000,
  parameter int BITRATE_BPS = 9_600,
  parameter int STOP_BITS   = 1,
  parameter int BIT_CLK     = CLK_HZ / BITRATE_BPS
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] data,
  input  logic       data_valid,
  output logic       ready,
  output logic       tx,
  output logic       busy
);

  localparam int               CNT_W     = (BIT_CLK > 1) ? $clog2(BIT_CLK) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(BIT_CLK - 1);
  localparam logic [2:0]       STOP_LAST = 3'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_STOP   = 3'd3
`ifdef UART_TX_PARITY_EN
    , S_PARITY = 3'd4
`endif
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             tx_q, tx_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
`ifdef UART_TX_PARITY_EN
  logic             parity_q, parity_d;
`endif

  logic accept;
  logic bit_end;

  assign accept  = data_valid && ready_q;
  assign bit_end = (bit_cnt_q == CNT_LAST);

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      bit_cnt_q <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
`ifdef UART_TX_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_START;
      S_START: if (bit_end) state_d = S_DATA;
      S_DATA: begin
        if (bit_end && bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
          state_d = S_PARITY;
`else
          state_d = S_STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: if (bit_end) state_d = S_STOP;
`endif
      S_STOP:  if (bit_end && bit_idx_q == STOP_LAST) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output / datapath next values; outputs are registered from the next
  // state so tx, ready and busy change on the same edge as the state.
  always_comb begin
    bit_cnt_d = (state_q == S_IDLE || bit_end) ? '0 : bit_cnt_q + 1'b1;
    // Index counts data bits in DATA and stop bits in STOP; any state
    // change restarts it.
    if (state_d != state_q) begin
      bit_idx_d = '0;
    end else if (bit_end) begin
      bit_idx_d = bit_idx_q + 3'd1;
    end else begin
      bit_idx_d = bit_idx_q;
    end

    shift_d = shift_q;
    if (state_q == S_IDLE && accept) begin
      shift_d = data;
    end else if (state_q == S_DATA && bit_end) begin
      shift_d = {1'b0, shift_q[7:1]};
    end

`ifdef UART_TX_PARITY_EN
    parity_d = parity_q;
    if (state_q == S_IDLE && accept) begin
      parity_d = ^data;
    end
`endif

    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      S_PARITY: tx_d = parity_q;
`endif
      default:  tx_d = 1'b1;
    endcase

    ready_d = (state_d == S_IDLE);
    busy_d  = (state_d != S_IDLE);
  end

  assign tx    = tx_q;
  assign ready = ready_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - scoreboard bench for uart_tx (line decoder + timing checks)
module tb_uart_tx;

  localparam int B    = 8;
  localparam int STOP = 1;
`ifdef UART_TX_PARITY_EN
  localparam int PAR  = 1;
`else
  localparam int PAR  = 0;
`endif
  localparam int NSLOT     = 1 + 8 + PAR + STOP;
  localparam int FRAME_CYC = NSLOT * B;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] data;
  logic       data_valid;
  logic       ready;
  logic       tx;
  logic       busy;

  typedef struct {
    logic [7:0] b;
    bit         gap_chk;
  } exp_t;

  exp_t exp_q[$];
  int   errors  = 0;
  int   checks  = 0;
  int   frames  = 0;
  int   aborted = 0;

  uart_tx #(
    .CLK_HZ      (66_000_000),
    .BITRATE_BPS (9_600),
    .STOP_BITS   (STOP),
    .BIT_CLK     (B)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .data       (data),
    .data_valid (data_valid),
    .ready      (ready),
    .tx         (tx),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the handshake edge.
  task automatic send_byte(input logic [7:0] b, input bit keep, input bit gap_chk);
    int   n;
    exp_t e;
    n          = 0;
    data       = b;
    data_valid = 1'b1;
    while (ready !== 1'b1 && n < FRAME_CYC * 2) begin
      @(negedge clk);
      n++;
    end
    if (ready !== 1'b1) begin
      check_eq("accept_timeout", {31'd0, ready}, 32'd1);
    end else begin
      e.b       = b;
      e.gap_chk = gap_chk;
      exp_q.push_back(e);
    end
    @(posedge clk);
    @(negedge clk);
    if (!keep) data_valid = 1'b0;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (ready !== 1'b1 && n < FRAME_CYC * 3) begin
      @(negedge clk);
      n++;
    end
  endtask

  // Line decoder: one sample per negedge, every bit must hold for B samples.
  initial begin : monitor
    int         gap;
    int         viol;
    bit         ab;
    logic       lvl [NSLOT];
    logic [7:0] rb;
    exp_t       e;
    gap = 0;
    forever begin
      @(negedge clk);
      if (rst_n !== 1'b1) begin
        gap = 0;
      end else if (tx === 1'b1) begin
        gap++;
      end else begin
        viol = 0;
        ab   = 1'b0;
        for (int s = 0; s < NSLOT; s++) begin
          for (int c = 0; c < B; c++) begin
            if (!ab) begin
              if (s != 0 || c != 0) @(negedge clk);
              if (rst_n !== 1'b1) ab = 1'b1;
              else if (c == 0) lvl[s] = tx;
              else if (tx !== lvl[s]) viol++;
            end
          end
        end
        if (exp_q.size() == 0) begin
          check_eq("unexpected_frame", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          if (ab) begin
            aborted++;
          end else begin
            frames++;
            if (e.gap_chk) check_eq("gap", STOP * B + gap, STOP * B + 1);
            check_eq("start", {31'd0, lvl[0]}, 32'd0);
            for (int i = 0; i < 8; i++) rb[i] = lvl[1 + i];
            check_eq("data", {24'd0, rb}, {24'd0, e.b});
`ifdef UART_TX_PARITY_EN
            check_eq("parity", {31'd0, lvl[9]}, {31'd0, ^e.b});
`endif
            for (int k = 0; k < STOP; k++) check_eq("stop", {31'd0, lvl[9 + PAR + k]}, 32'd1);
            check_eq("hold", viol, 0);
          end
        end
        gap = 0;
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int n;
    int viol;
    rst_n      = 1'b0;
    data_valid = 1'b0;
    data       = 8'h00;
    repeat (5) @(negedge clk);
    check_eq("rst_tx", {31'd0, tx}, 32'd1);
    check_eq("rst_ready", {31'd0, ready}, 32'd0);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    rst_n = 1'b1;
    #1;
    check_eq("ready_first_cycle", {31'd0, ready}, 32'd0);
    viol = 0;
    repeat (20) begin
      @(negedge clk);
      if (tx !== 1'b1 || ready !== 1'b1 || busy !== 1'b0) viol++;
    end
    check_eq("idle", viol, 0);

    // Single byte and frame length
    send_byte(8'hA1, 1'b0, 1'b0);
    check_eq("busy_in_frame", {31'd0, busy}, 32'd1);
    wait_ready(n);
    check_eq("a1_len", n, FRAME_CYC);
    check_eq("a1_busy_end", {31'd0, busy}, 32'd0);
    repeat (5) @(negedge clk);

    // Back-to-back with data_valid held
    send_byte(8'hA2, 1'b1, 1'b0);
    send_byte(8'hA3, 1'b0, 1'b1);
    wait_ready(n);
    check_eq("a3_len", n, FRAME_CYC);
    repeat (3) @(negedge clk);

    // Data change after accept, valid pulses while busy
    send_byte(8'hA5, 1'b0, 1'b0);
    data = 8'h00;
    repeat (3) begin
      repeat (2 * B) @(negedge clk);
      data       = 8'hFF;
      data_valid = 1'b1;
      @(negedge clk);
      data_valid = 1'b0;
      data       = 8'h00;
    end
    check_eq("busy_mid_a5", {31'd0, busy}, 32'd1);
    wait_ready(n);
    check_eq("a5_done", {31'd0, ready}, 32'd1);
    repeat (3) @(negedge clk);

    // Reset during data bit 3 of 0xA6 (bit 3 is 0)
    send_byte(8'hA6, 1'b0, 1'b0);
    repeat (4 * B + B / 2 - 1) @(negedge clk);
    check_eq("pre_rst_tx", {31'd0, tx}, 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_tx", {31'd0, tx}, 32'd1);
    check_eq("mid_rst_ready", {31'd0, ready}, 32'd0);
    check_eq("mid_rst_busy", {31'd0, busy}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_eq("rel_ready_first", {31'd0, ready}, 32'd0);
    @(negedge clk);
    check_eq("rel_ready_second", {31'd0, ready}, 32'd1);
    check_eq("rel_tx", {31'd0, tx}, 32'd1);

    send_byte(8'h5A, 1'b0, 1'b0);
    wait_ready(n);
    check_eq("5a_len", n, FRAME_CYC);
    repeat (5) @(negedge clk);

    check_eq("queue_empty", exp_q.size(), 0);
    check_eq("frames", frames, 5);
    check_eq("aborted", aborted, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
